fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline.
- Holds the PC and issues one-outstanding-request fetches to a variable-latency instruction memory.
- Registers the fetched word into IF/ID, which drives opCode straight into the control unit.
- Honours the hazard unit's stallSignal and the EX/MEM branch redirect (flush).

---
 rtl/fetch_stage_if.sv | 18 +
 rtl/fetch_stage.sv | 150 +++++++++++++++
 tb/tb_fetch_stage.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch port shared by the fetch stage and the memory.
//   imemReq   : request valid (held high until imemReady while a fetch is open)
//   imemAddr  : fetch address, stable while imemReq=1 until imemReady
//   imemReady : one-cycle pulse, imemData valid for the outstanding request
//   imemData  : fetched instruction word
// master = fetch stage side, slave = memory side.
interface fetch_stage_if #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   imemReq;
  logic [PC_WIDTH-1:0]    imemAddr;
  logic                   imemReady;
  logic [INSTR_WIDTH-1:0] imemData;

  modport master (output imemReq, imemAddr, input imemReady, imemData);
  modport slave  (input imemReq, imemAddr, output imemReady, imemData);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for a 5-stage MIPS.
// Keeps a single fetch outstanding to a variable-latency instruction memory,
// honours the hazard unit's stall and the EX/MEM branch redirect (flush).
// Ports:
//   clk, rst_n    : rising-edge clock, asynchronous active-low reset
//   stallSignal   : hold PC and IF/ID contents
//   branchTaken   : redirect to branchTarget and bubble IF/ID (beats stall)
//   branchTarget  : redirect address, low two bits ignored
//   imem          : fetch port (fetch_stage_if.master)
//   ifidInstr     : IF/ID instruction, all-zero when bubbled
//   ifidPcPlus4   : PC+4 belonging to ifidInstr
//   ifidValid     : IF/ID holds a real instruction
//   opCode        : top six bits of ifidInstr, fed to the control unit
module fetch_stage #(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stallSignal,
  input  logic                   branchTaken,
  input  logic [PC_WIDTH-1:0]    branchTarget,
  fetch_stage_if.master          imem,
  output logic [INSTR_WIDTH-1:0] ifidInstr,
  output logic [PC_WIDTH-1:0]    ifidPcPlus4,
  output logic                   ifidValid,
  output logic [5:0]             opCode
);

  // IDLE    : no request open, launch one next cycle
  // REQ     : request open, its data is wanted
  // HOLD    : data arrived during a stall and waits in the holding buffer
  // DISCARD : request open but a branch made its data stale
  typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} state_t;

  state_t                 state, state_d;
  logic [PC_WIDTH-1:0]    pc, pc_d;
  logic [PC_WIDTH-1:0]    req_addr, req_addr_d;
  logic [PC_WIDTH-1:0]    target, pc_plus4;
  logic [INSTR_WIDTH-1:0] instr_d, buf_instr, buf_instr_d;
  logic [PC_WIDTH-1:0]    pc4_d, buf_pc4, buf_pc4_d;
  logic                   valid_d;

  // Word-align the redirect address.
  assign target   = branchTarget & {{(PC_WIDTH-2){1'b1}}, 2'b00};
  assign pc_plus4 = pc + PC_WIDTH'(4);

  assign imem.imemAddr = req_addr;
  // A request stays open until imemReady, whether or not its data is wanted.
  assign imem.imemReq  = (state == REQ) || (state == DISCARD);
  assign opCode        = ifidInstr[INSTR_WIDTH-1 -: 6];

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    state_d     = state;
    pc_d        = pc;
    req_addr_d  = req_addr;
    instr_d     = ifidInstr;
    pc4_d       = ifidPcPlus4;
    valid_d     = ifidValid;
    buf_instr_d = buf_instr;
    buf_pc4_d   = buf_pc4;

    // Bubble unless stalled; a flush bubbles even under stall. Loads below
    // override this when an instruction actually moves into IF/ID.
    if (branchTaken || !stallSignal) begin
      instr_d = '0;
      valid_d = 1'b0;
    end

    unique case (state)
      IDLE: begin
        state_d    = REQ;
        req_addr_d = branchTaken ? target : pc;
        if (branchTaken) pc_d = target;
      end
      REQ: begin
        if (branchTaken) begin
          pc_d = target;
          // Data arriving with the flush is dropped; otherwise the request
          // must be drained before the target can be fetched.
          if (imem.imemReady) req_addr_d = target;
          else                state_d    = DISCARD;
        end else if (imem.imemReady) begin
          if (!stallSignal) begin
            instr_d    = imem.imemData;
            pc4_d      = pc_plus4;
            valid_d    = 1'b1;
            pc_d       = pc_plus4;
            req_addr_d = pc_plus4;
          end else begin
            buf_instr_d = imem.imemData;
            buf_pc4_d   = pc_plus4;
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        if (branchTaken) begin
          pc_d    = target;
          state_d = IDLE;
        end else if (!stallSignal) begin
          instr_d = buf_instr;
          pc4_d   = buf_pc4;
          valid_d = 1'b1;
          pc_d    = buf_pc4;
          state_d = IDLE;
        end
      end
      DISCARD: begin
        // pc carries the newest redirect while the stale fetch drains.
        if (branchTaken) pc_d = target;
        if (imem.imemReady) begin
          req_addr_d = branchTaken ? target : pc;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      ifidInstr   <= '0;
      ifidPcPlus4 <= '0;
      ifidValid   <= 1'b0;
      // NOTE: the holding buffer is a plain register, not a memory, so it is
      // reset with everything else and never exposes stale contents.
      buf_instr   <= '0;
      buf_pc4     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the same clock edge, independent of statement order.
      state       <= state_d;
      pc          <= pc_d;
      req_addr    <= req_addr_d;
      ifidInstr   <= instr_d;
      ifidPcPlus4 <= pc4_d;
      ifidValid   <= valid_d;
      buf_instr   <= buf_instr_d;
      buf_pc4     <= buf_pc4_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with fixed expectations plus a
// randomized run checked against a program-order reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] target = '0;
  logic [31:0] ifid_instr, ifid_pc4;
  logic        ifid_valid;
  logic [5:0]  op_code;

  int checks = 0;
  int errors = 0;

  fetch_stage_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) bus ();

  fetch_stage #(.PC_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .stallSignal(stall), .branchTaken(branch),
    .branchTarget(target), .imem(bus), .ifidInstr(ifid_instr),
    .ifidPcPlus4(ifid_pc4), .ifidValid(ifid_valid), .opCode(op_code)
  );

  always #5 clk = ~clk;

  // Program image: address-as-data, except a lw (opcode 0x23) at 0x0C.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0000_000C) ? 32'h8C22_0004 : a;
  endfunction

  // Instruction memory: answers lat_cfg cycles after a request opens
  // (0 = same cycle) and counts address changes on an open request.
  int          lat_cfg = 0;
  bit          lat_rand = 1'b0;
  bit          mem_inject = 1'b0;
  int          mem_cnt = 0;
  int          mem_addr_err = 0;
  logic [31:0] mem_seen = '0;

  initial begin
    bus.imemReady = 1'b0;
    bus.imemData  = '0;
  end

  always @(negedge clk) begin
    if (mem_inject) begin
      bus.imemReady = 1'b1;
      bus.imemData  = 32'hDEAD_BEEF;
      mem_cnt       = 0;
    end else if (!rst_n || !bus.imemReq) begin
      bus.imemReady = 1'b0;
      mem_cnt       = 0;
    end else begin
      if (mem_cnt == 0) mem_seen = bus.imemAddr;
      else if (bus.imemAddr !== mem_seen) mem_addr_err++;
      if (mem_cnt >= lat_cfg) begin
        bus.imemReady = 1'b1;
        bus.imemData  = mem_word(bus.imemAddr);
        mem_cnt       = 0;
        if (lat_rand) lat_cfg = int'($urandom_range(0, 3));
      end else begin
        bus.imemReady = 1'b0;
        mem_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset with the given memory latency; returns at the negedge where rst_n
  // is released, so the next posedge is the first active one.
  task automatic do_reset(input int lat);
    rst_n = 1'b0; stall = 1'b0; branch = 1'b0; target = '0;
    mem_inject = 1'b0; lat_rand = 1'b0; lat_cfg = lat; mem_addr_err = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (bus.imemReq !== 1'b0 || bus.imemAddr !== 32'h0 || ifid_instr !== 32'h0 ||
        ifid_pc4 !== 32'h0 || ifid_valid !== 1'b0 || op_code !== 6'h0)
      begin errors++; $display("FAIL reset_state: req=%b addr=%h instr=%h pc4=%h valid=%b op=%h, want all zero",
        bus.imemReq, bus.imemAddr, ifid_instr, ifid_pc4, ifid_valid, op_code); end
    do_reset(0);
    checks++;
    if (bus.imemReq !== 1'b0)
      begin errors++; $display("FAIL reset_idle_req: req=%b want 0", bus.imemReq); end
  endtask

  // Request index after edge k is (k-1)/(L+1); instruction m lands on edge
  // 1+(m+1)*(L+1).
  task automatic test_latency(input int lat, input int edges);
    logic [31:0] exp_addr, w;
    int m;
    do_reset(lat);
    for (int k = 1; k <= edges; k++) begin
      tick();
      exp_addr = 32'(4 * ((k - 1) / (lat + 1)));
      checks++;
      if (bus.imemReq !== 1'b1 || bus.imemAddr !== exp_addr)
        begin errors++; $display("FAIL lat%0d_addr edge %0d: req=%b addr=%h want 1/%h",
          lat, k, bus.imemReq, bus.imemAddr, exp_addr); end
      checks++;
      if (k > 1 && (k - 1) % (lat + 1) == 0) begin
        m = (k - 1) / (lat + 1) - 1;
        w = mem_word(32'(4 * m));
        if (ifid_instr !== w || ifid_pc4 !== 32'(4 * m + 4) || ifid_valid !== 1'b1 || op_code !== w[31:26])
          begin errors++; $display("FAIL lat%0d_load edge %0d: instr=%h pc4=%h valid=%b op=%h want %h/%h/1/%h",
            lat, k, ifid_instr, ifid_pc4, ifid_valid, op_code, w, 4 * m + 4, w[31:26]); end
      end else begin
        if (ifid_instr !== 32'h0 || ifid_valid !== 1'b0)
          begin errors++; $display("FAIL lat%0d_bubble edge %0d: instr=%h valid=%b want 0/0",
            lat, k, ifid_instr, ifid_valid); end
      end
    end
  endtask

  task automatic test_stall_hold();
    do_reset(0);
    repeat (5) tick();
    @(negedge clk);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.imemReq !== 1'b0 || ifid_instr !== 32'h8C22_0004 || ifid_pc4 !== 32'h10 || ifid_valid !== 1'b1)
        begin errors++; $display("FAIL stall_hold cycle %0d: req=%b instr=%h pc4=%h valid=%b want 0/8c220004/10/1",
          i, bus.imemReq, ifid_instr, ifid_pc4, ifid_valid); end
    end
    @(negedge clk);
    stall = 1'b0;
    tick();
    checks++;
    if (ifid_instr !== 32'h10 || ifid_pc4 !== 32'h14 || ifid_valid !== 1'b1)
      begin errors++; $display("FAIL stall_release: instr=%h pc4=%h valid=%b want 10/14/1",
        ifid_instr, ifid_pc4, ifid_valid); end
    tick();
    checks++;
    if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h14)
      begin errors++; $display("FAIL stall_next_req: req=%b addr=%h want 1/14", bus.imemReq, bus.imemAddr); end
  endtask

  task automatic test_branch_pending();
    do_reset(2);
    repeat (7) tick();
    checks++;
    if (ifid_instr !== 32'h4 || ifid_valid !== 1'b1 || bus.imemAddr !== 32'h8)
      begin errors++; $display("FAIL bp_pre: instr=%h valid=%b addr=%h want 4/1/8",
        ifid_instr, ifid_valid, bus.imemAddr); end
    @(negedge clk);
    branch = 1'b1; target = 32'h40;
    tick();
    @(negedge clk);
    branch = 1'b0;
    // Edges 8..12 relative to reset: drain the stale fetch, then fetch 0x40.
    for (int k = 8; k <= 12; k++) begin
      checks++;
      if (bus.imemReq !== 1'b1 || bus.imemAddr !== ((k <= 9) ? 32'h8 : 32'h40) ||
          ifid_valid !== 1'b0 || ifid_instr !== 32'h0)
        begin errors++; $display("FAIL bp_drain edge %0d: req=%b addr=%h valid=%b instr=%h want 1/%h/0/0",
          k, bus.imemReq, bus.imemAddr, ifid_valid, ifid_instr, (k <= 9) ? 32'h8 : 32'h40); end
      tick();
    end
    checks++;
    if (ifid_instr !== 32'h40 || ifid_pc4 !== 32'h44 || ifid_valid !== 1'b1)
      begin errors++; $display("FAIL bp_target: instr=%h pc4=%h valid=%b want 40/44/1",
        ifid_instr, ifid_pc4, ifid_valid); end
  endtask

  task automatic test_branch_stall();
    do_reset(0);
    repeat (4) tick();
    checks++;
    if (ifid_instr !== 32'h8 || ifid_valid !== 1'b1)
      begin errors++; $display("FAIL bs_pre: instr=%h valid=%b want 8/1", ifid_instr, ifid_valid); end
    @(negedge clk);
    stall = 1'b1; branch = 1'b1; target = 32'h83;
    tick();
    checks++;
    if (ifid_instr !== 32'h0 || ifid_valid !== 1'b0 || bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h80)
      begin errors++; $display("FAIL bs_flush: instr=%h valid=%b req=%b addr=%h want 0/0/1/80",
        ifid_instr, ifid_valid, bus.imemReq, bus.imemAddr); end
    @(negedge clk);
    stall = 1'b0; branch = 1'b0;
    tick();
    checks++;
    if (ifid_instr !== 32'h80 || ifid_pc4 !== 32'h84 || ifid_valid !== 1'b1 || bus.imemAddr !== 32'h84)
      begin errors++; $display("FAIL bs_resume: instr=%h pc4=%h valid=%b addr=%h want 80/84/1/84",
        ifid_instr, ifid_pc4, ifid_valid, bus.imemAddr); end
  endtask

  task automatic test_wrap();
    do_reset(0);
    repeat (2) tick();
    @(negedge clk);
    branch = 1'b1; target = 32'hFFFF_FFFF;
    tick();
    checks++;
    if (bus.imemAddr !== 32'hFFFF_FFFC || ifid_valid !== 1'b0)
      begin errors++; $display("FAIL wrap_addr: addr=%h valid=%b want fffffffc/0", bus.imemAddr, ifid_valid); end
    @(negedge clk);
    branch = 1'b0;
    tick();
    checks++;
    if (ifid_instr !== 32'hFFFF_FFFC || ifid_pc4 !== 32'h0 || ifid_valid !== 1'b1 ||
        op_code !== 6'h3F || bus.imemAddr !== 32'h0)
      begin errors++; $display("FAIL wrap_load: instr=%h pc4=%h valid=%b op=%h addr=%h want fffffffc/0/1/3f/0",
        ifid_instr, ifid_pc4, ifid_valid, op_code, bus.imemAddr); end
  endtask

  task automatic test_async_reset();
    do_reset(3);
    repeat (9) tick();
    checks++;
    if (ifid_instr !== 32'h4 || ifid_pc4 !== 32'h8 || ifid_valid !== 1'b1 || bus.imemAddr !== 32'h8)
      begin errors++; $display("FAIL ar_pre: instr=%h pc4=%h valid=%b addr=%h want 4/8/1/8",
        ifid_instr, ifid_pc4, ifid_valid, bus.imemAddr); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.imemReq !== 1'b0 || bus.imemAddr !== 32'h0 || ifid_instr !== 32'h0 ||
        ifid_pc4 !== 32'h0 || ifid_valid !== 1'b0 || op_code !== 6'h0)
      begin errors++; $display("FAIL ar_async: req=%b addr=%h instr=%h pc4=%h valid=%b op=%h want all zero",
        bus.imemReq, bus.imemAddr, ifid_instr, ifid_pc4, ifid_valid, op_code); end
    @(posedge clk);
    #1;
    mem_inject = 1'b1;
    rst_n = 1'b1;
    tick();
    mem_inject = 1'b0;
    checks++;
    if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h0 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0)
      begin errors++; $display("FAIL ar_stray_ready: req=%b addr=%h valid=%b instr=%h want 1/0/0/0",
        bus.imemReq, bus.imemAddr, ifid_valid, ifid_instr); end
    repeat (4) tick();
    checks++;
    if (ifid_instr !== 32'h0 || ifid_pc4 !== 32'h4 || ifid_valid !== 1'b1)
      begin errors++; $display("FAIL ar_refetch: instr=%h pc4=%h valid=%b want 0/4/1",
        ifid_instr, ifid_pc4, ifid_valid); end
  endtask

  // Program-order model: every instruction entering IF/ID must be the next
  // word of the current path; a branch restarts the path at its target.
  task automatic test_random();
    logic [31:0] exp_pc, exp_instr, exp_pc4, w, tgt;
    logic        exp_valid;
    int          delivered = 0;
    do_reset(0);
    lat_rand  = 1'b1;
    exp_pc    = 32'h0;
    exp_instr = 32'h0; exp_pc4 = 32'h0; exp_valid = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      stall  = ($urandom_range(0, 3) == 0);
      branch = ($urandom_range(0, 15) == 0);
      target = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
      tick();
      checks++;
      if (branch) begin
        tgt = target & 32'hFFFF_FFFC;
        if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0)
          begin errors++; $display("FAIL rnd_flush cycle %0d: valid=%b instr=%h want 0/0", c, ifid_valid, ifid_instr); end
        exp_pc = tgt; exp_instr = 32'h0; exp_valid = 1'b0;
      end else if (stall) begin
        if (ifid_valid !== exp_valid || ifid_instr !== exp_instr || (exp_valid && ifid_pc4 !== exp_pc4))
          begin errors++; $display("FAIL rnd_hold cycle %0d: instr=%h pc4=%h valid=%b want %h/%h/%b",
            c, ifid_instr, ifid_pc4, ifid_valid, exp_instr, exp_pc4, exp_valid); end
      end else if (ifid_valid === 1'b1) begin
        w = mem_word(exp_pc);
        if (ifid_instr !== w || ifid_pc4 !== exp_pc + 32'd4 || op_code !== w[31:26])
          begin errors++; $display("FAIL rnd_load cycle %0d: instr=%h pc4=%h op=%h want %h/%h/%h",
            c, ifid_instr, ifid_pc4, op_code, w, exp_pc + 32'd4, w[31:26]); end
        exp_instr = w; exp_pc4 = exp_pc + 32'd4; exp_valid = 1'b1;
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end else begin
        if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0)
          begin errors++; $display("FAIL rnd_bubble cycle %0d: valid=%b instr=%h want 0/0", c, ifid_valid, ifid_instr); end
        exp_instr = 32'h0; exp_valid = 1'b0;
      end
    end
    @(negedge clk);
    stall = 1'b0; branch = 1'b0; lat_rand = 1'b0;
    checks++;
    if (delivered < 50)
      begin errors++; $display("FAIL rnd_progress: delivered %0d want at least 50", delivered); end
    checks++;
    if (mem_addr_err != 0)
      begin errors++; $display("FAIL rnd_addr_stable: %0d address changes on open requests want 0", mem_addr_err); end
  endtask

  initial begin
    test_reset();
    test_latency(0, 10);
    test_latency(3, 10);
    test_latency(1, 8);
    test_stall_hold();
    test_branch_pending();
    test_branch_stall();
    test_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
